// File: rtl/alu_pkg.sv
// alu_pkg: ALU widths, opcode tags and the buffered result entry shared by the ALU, its capture stage and benches.
package alu_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] OP_NOT  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] OP_SLL  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] OP_SRL  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] OP_SRA  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] OP_ROL  = 4'b1001;
    localparam logic [ALU_OP_W-1:0] OP_ROR  = 4'b1010;
    localparam logic [ALU_OP_W-1:0] OP_INC  = 4'b1011;
    localparam logic [ALU_OP_W-1:0] OP_DEC  = 4'b1100;
    localparam logic [ALU_OP_W-1:0] OP_PASA = 4'b1101;
    localparam logic [ALU_OP_W-1:0] OP_PASB = 4'b1110;
    localparam logic [ALU_OP_W-1:0] OP_NOP  = 4'b1111;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] data;
        logic [ALU_OP_W-1:0]   opcode;
        logic                  carry;
        logic                  zero;
        logic                  neg;
    } alu_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// alu_res_fifo: synchronous FIFO of alu_entry_t; head reads as zero while empty so outputs are clean after reset.
module alu_res_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  alu_entry_t    din,
    output alu_entry_t    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    alu_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd    = pop & ~empty;
    // a pop frees the slot in the same edge, so a full FIFO still takes the push
    assign wr    = push & (~full | rd);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(wr) - CW'(rd);
        end
    end

endmodule

// File: rtl/alu_res_buffer.sv
// alu_res_buffer: captures ALU results with flags into a FIFO, valid/ready output, sticky overflow on drops.
// Optional ALU_RES_DROP_CNT_EN adds an 8-bit saturating drop_cnt output.
module alu_res_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [OP_W-1:0]          opcode,
    input  logic [DATA_W:0]          ALU_res,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [OP_W-1:0]          out_opcode,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count,
`ifdef ALU_RES_DROP_CNT_EN
    output logic [7:0]               drop_cnt,
`endif
    output logic                     overflow
);

    alu_entry_t din, head;
    logic       full, empty, pop, drop;

    assign din = '{data:   ALU_res[DATA_W-1:0],
                   opcode: opcode,
                   carry:  ALU_res[DATA_W],
                   zero:   ~|ALU_res[DATA_W-1:0],
                   neg:    ALU_res[DATA_W-1]};

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign drop      = en & full & ~pop;

    assign out_data   = head.data;
    assign out_opcode = head.opcode;
    assign out_carry  = head.carry;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;

    alu_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (en),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef ALU_RES_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_alu_res_buffer.sv
// tb_alu_res_buffer: directed table-driven bench for alu_res_buffer plus streaming and reset corner sequences.
module tb_alu_res_buffer;

    logic        clk = 1'b0;
    logic        rst_n, en, out_ready;
    logic [3:0]  opcode;
    logic [32:0] ALU_res;
    logic        out_valid, out_carry, out_zero, out_neg, overflow;
    logic [31:0] out_data;
    logic [3:0]  out_opcode;
    logic [2:0]  count;
    logic [7:0]  drop_obs;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_res_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .opcode     (opcode),
        .ALU_res    (ALU_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_opcode (out_opcode),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .count      (count),
`ifdef ALU_RES_DROP_CNT_EN
        .drop_cnt   (drop_obs),
`endif
        .overflow   (overflow)
    );

`ifndef ALU_RES_DROP_CNT_EN
    assign drop_obs = 8'd0;
`endif

    typedef struct {
        logic        r, e;
        logic [3:0]  op;
        logic [32:0] res;
        logic        rdy;
        logic        v;
        logic [31:0] d;
        logic [3:0]  eo;
        logic        c, z, n;
        logic [2:0]  cnt;
        logic        ovf;
        logic [7:0]  drop;
    } vec_t;

    function automatic vec_t mk(logic r, logic e, logic [3:0] op, logic [32:0] res, logic rdy,
                                logic v, logic [31:0] d, logic [3:0] eo, logic c, logic z, logic n,
                                logic [2:0] cnt, logic ovf, logic [7:0] drop);
        vec_t t;
        t = '{r, e, op, res, rdy, v, d, eo, c, z, n, cnt, ovf, drop};
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] op, input logic [32:0] res, input logic rdy);
        @(negedge clk);
        rst_n = r; en = e; opcode = op; ALU_res = res; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t t);
        chk({tag, " valid"}, 64'(out_valid), 64'(t.v));
        chk({tag, " data"}, 64'(out_data), 64'(t.d));
        chk({tag, " opcode"}, 64'(out_opcode), 64'(t.eo));
        chk({tag, " carry"}, 64'(out_carry), 64'(t.c));
        chk({tag, " zero"}, 64'(out_zero), 64'(t.z));
        chk({tag, " neg"}, 64'(out_neg), 64'(t.n));
        chk({tag, " count"}, 64'(count), 64'(t.cnt));
        chk({tag, " overflow"}, 64'(overflow), 64'(t.ovf));
`ifdef ALU_RES_DROP_CNT_EN
        chk({tag, " drop_cnt"}, 64'(drop_obs), 64'(t.drop));
`endif
    endtask

    vec_t v [25];

    initial begin
        rst_n = 1'b0; en = 1'b0; opcode = '0; ALU_res = '0; out_ready = 1'b0;
        v[0]  = mk(0,0,0,0,0,                  0,0,0,0,0,0,0,0,0);
        v[1]  = mk(1,1,0,33'd6,0,              1,6,0,0,0,0,1,0,0);
        v[2]  = mk(1,0,0,0,1,                  0,0,0,0,0,0,0,0,0);
        v[3]  = mk(1,1,1,33'h1_0000_0000,0,    1,0,1,1,1,0,1,0,0);
        v[4]  = mk(1,1,2,33'h0_8000_0000,1,    1,32'h8000_0000,2,0,0,1,1,0,0);
        v[5]  = mk(1,0,0,0,1,                  0,0,0,0,0,0,0,0,0);
        v[6]  = mk(1,1,3,33'd1,0,              1,1,3,0,0,0,1,0,0);
        v[7]  = mk(1,1,3,33'd2,0,              1,1,3,0,0,0,2,0,0);
        v[8]  = mk(1,1,3,33'd3,0,              1,1,3,0,0,0,3,0,0);
        v[9]  = mk(1,1,3,33'd4,0,              1,1,3,0,0,0,4,0,0);
        v[10] = mk(1,1,3,33'd5,0,              1,1,3,0,0,0,4,1,1);
        v[11] = mk(1,0,0,0,1,                  1,2,3,0,0,0,3,1,1);
        v[12] = mk(1,0,0,0,1,                  1,3,3,0,0,0,2,1,1);
        v[13] = mk(1,0,0,0,1,                  1,4,3,0,0,0,1,1,1);
        v[14] = mk(1,0,0,0,1,                  0,0,0,0,0,0,0,1,1);
        v[15] = mk(0,0,0,0,0,                  0,0,0,0,0,0,0,0,0);
        v[16] = mk(1,1,4,33'd10,0,             1,10,4,0,0,0,1,0,0);
        v[17] = mk(1,1,4,33'd11,0,             1,10,4,0,0,0,2,0,0);
        v[18] = mk(1,1,4,33'd12,0,             1,10,4,0,0,0,3,0,0);
        v[19] = mk(1,1,4,33'd13,0,             1,10,4,0,0,0,4,0,0);
        v[20] = mk(1,1,4,33'd14,1,             1,11,4,0,0,0,4,0,0);
        v[21] = mk(1,0,0,0,1,                  1,12,4,0,0,0,3,0,0);
        v[22] = mk(1,0,0,0,1,                  1,13,4,0,0,0,2,0,0);
        v[23] = mk(1,0,0,0,1,                  1,14,4,0,0,0,1,0,0);
        v[24] = mk(1,0,0,0,1,                  0,0,0,0,0,0,0,0,0);

        for (int i = 0; i < 25; i++) begin
            step(v[i].r, v[i].e, v[i].op, v[i].res, v[i].rdy);
            chk_all($sformatf("row%0d", i), v[i]);
        end

        // streaming: one result per cycle through several pointer wraps
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 4'd5, 33'(100 + i), 1);
            chk($sformatf("stream%0d data", i), 64'(out_data), 64'(100 + i));
            chk($sformatf("stream%0d count", i), 64'(count), 64'd1);
            chk($sformatf("stream%0d valid", i), 64'(out_valid), 64'd1);
        end
        step(1, 0, 0, 0, 1);
        chk("stream end valid", 64'(out_valid), 64'd0);
        chk("stream end ovf", 64'(overflow), 64'd0);

        // reset with entries queued and overflow set
        for (int i = 1; i <= 5; i++) step(1, 1, 4'd6, 33'(i), 0);
        step(1, 0, 0, 0, 1);
        chk("pre-reset count", 64'(count), 64'd3);
        chk("pre-reset ovf", 64'(overflow), 64'd1);
        chk("pre-reset head", 64'(out_data), 64'd2);
        step(0, 0, 0, 0, 0);
        chk_all("midreset", mk(0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        step(1, 1, 4'd7, 33'd7, 0);
        chk_all("post-reset push", mk(1,1,7,33'd7,0, 1,7,7,0,0,0,1,0,0));
        step(1, 0, 0, 0, 1);
        chk("post-reset drain valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
